// File: rtl/irq_sequencer_pkg.sv
// rtl/irq_sequencer_pkg.sv - shared state encoding, vector table and stack constants for irq_sequencer
package irq_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PUSH_PC,
    PUSH_SR,
    FETCH_VEC,
    ENTER,
    ISR,
    POP_SR,
    POP_PC,
    EXIT
  } state_e;

  localparam logic [15:0] VEC_SLOT_0 = 16'hFFF0;
  localparam logic [15:0] VEC_SLOT_1 = 16'hFFF2;
  localparam logic [15:0] VEC_SLOT_2 = 16'hFFFA;
  localparam logic [15:0] VEC_SLOT_3 = 16'hFFFC;

  localparam logic [15:0] STACK_STEP  = 16'd2;
  localparam logic [15:0] STACK_FRAME = STACK_STEP + STACK_STEP;

  function automatic logic is_mem_state(input state_e s);
    return (s == PUSH_PC) || (s == PUSH_SR) || (s == FETCH_VEC) ||
           (s == POP_SR) || (s == POP_PC);
  endfunction

endpackage

// File: rtl/irq_mem_timer.sv
// rtl/irq_mem_timer.sv - counts consecutive memory wait cycles and flags when the wait limit is reached
module irq_mem_timer #(
  parameter int LIMIT = 16,
  parameter bit EN    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = run ? count_q + CW'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the LIMIT-th consecutive cycle spent waiting.
  assign expired = EN && run && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt entry/return sequencer: stacks PC/SR, fetches vector, restores on RETI
// Optional MEM_TIMEOUT_EN: abort a memory wait after MEM_TIMEOUT cycles and pulse ERR
module irq_sequencer #(
  parameter int GIE_BIT     = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic [15:0] ADDRInt,
  input  logic        INSTR_DONE,
  input  logic        RETI_EXEC,
  input  logic [15:0] PC_IN,
  input  logic [15:0] SR_IN,
  input  logic [15:0] SP_IN,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_READY,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  output logic        MEM_RE,
  output logic        MEM_WE,
  output logic [15:0] PC_OUT,
  output logic [15:0] SR_OUT,
  output logic [15:0] SP_OUT,
  output logic        PC_LOAD,
  output logic        SR_LOAD,
  output logic        SP_LOAD,
  output logic        STALL,
  output logic        RTI,
  output logic        ISR_ACT,
  output logic        ERR
);
  import irq_sequencer_pkg::*;

  localparam logic [15:0] GIE_MASK = 16'(1) << GIE_BIT;
`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [15:0] vec_q, vec_d, pc_q, pc_d, sr_q, sr_d, sp_q, sp_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [15:0] pc_out_q, pc_out_d, sr_out_q, sr_out_d, sp_out_q, sp_out_d;
  logic        mem_re_q, mem_re_d, mem_we_q, mem_we_d, load_q, load_d;
  logic        stall_q, stall_d, rti_q, rti_d, isr_act_q, isr_act_d, err_q, err_d;
  logic        wait_run, timeout;

  assign wait_run = is_mem_state(state_q) && !MEM_READY;

  irq_mem_timer #(.LIMIT(MEM_TIMEOUT), .EN(TIMEOUT_EN)) u_mem_timer (
    .clk    (CLK),
    .reset  (RESET),
    .run    (wait_run),
    .expired(timeout)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pc_d    = pc_q;
    sr_d    = sr_q;
    sp_d    = sp_q;
    case (state_q)
      IDLE: if (REQ && SR_IN[GIE_BIT] && INSTR_DONE) begin
        state_d = PUSH_PC;
        vec_d   = ADDRInt;
        pc_d    = PC_IN;
        sr_d    = SR_IN;
        sp_d    = SP_IN;
      end
      PUSH_PC:   if (MEM_READY) state_d = PUSH_SR;
      PUSH_SR:   if (MEM_READY) state_d = FETCH_VEC;
      FETCH_VEC: if (MEM_READY) begin
        vec_d   = MEM_RDATA;
        state_d = ENTER;
      end
      ENTER:     state_d = ISR;
      ISR:       if (RETI_EXEC) begin
        sp_d    = SP_IN;
        state_d = POP_SR;
      end
      POP_SR:    if (MEM_READY) begin
        sr_d    = MEM_RDATA;
        state_d = POP_PC;
      end
      POP_PC:    if (MEM_READY) begin
        pc_d    = MEM_RDATA;
        state_d = EXIT;
      end
      default:   state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    pc_out_d    = '0;
    sr_out_d    = '0;
    sp_out_d    = '0;
    load_d      = 1'b0;
    rti_d       = 1'b0;
    err_d       = timeout;
    stall_d     = !((state_d == IDLE) || (state_d == ISR));
    isr_act_d   = (state_d == ISR);
    case (state_d)
      PUSH_PC: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = sp_d - STACK_STEP;
        mem_wdata_d = pc_d;
      end
      PUSH_SR: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = sp_d - STACK_FRAME;
        mem_wdata_d = sr_d;
      end
      FETCH_VEC: begin
        mem_re_d   = 1'b1;
        mem_addr_d = vec_d;
      end
      ENTER: begin
        pc_out_d = vec_d;
        sr_out_d = sr_d & ~GIE_MASK;
        sp_out_d = sp_d - STACK_FRAME;
        load_d   = 1'b1;
      end
      POP_SR: begin
        mem_re_d   = 1'b1;
        mem_addr_d = sp_d;
      end
      POP_PC: begin
        mem_re_d   = 1'b1;
        mem_addr_d = sp_d + STACK_STEP;
      end
      EXIT: begin
        pc_out_d = pc_d;
        sr_out_d = sr_d;
        sp_out_d = sp_d + STACK_FRAME;
        load_d   = 1'b1;
        rti_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      pc_q        <= '0;
      sr_q        <= '0;
      sp_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      pc_out_q    <= '0;
      sr_out_q    <= '0;
      sp_out_q    <= '0;
      load_q      <= 1'b0;
      stall_q     <= 1'b0;
      rti_q       <= 1'b0;
      isr_act_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      pc_q        <= pc_d;
      sr_q        <= sr_d;
      sp_q        <= sp_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      pc_out_q    <= pc_out_d;
      sr_out_q    <= sr_out_d;
      sp_out_q    <= sp_out_d;
      load_q      <= load_d;
      stall_q     <= stall_d;
      rti_q       <= rti_d;
      isr_act_q   <= isr_act_d;
      err_q       <= err_d;
    end
  end

  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MEM_RE    = mem_re_q;
  assign MEM_WE    = mem_we_q;
  assign PC_OUT    = pc_out_q;
  assign SR_OUT    = sr_out_q;
  assign SP_OUT    = sp_out_q;
  assign PC_LOAD   = load_q;
  assign SR_LOAD   = load_q;
  assign SP_LOAD   = load_q;
  assign STALL     = stall_q;
  assign RTI       = rti_q;
  assign ISR_ACT   = isr_act_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - self-checking bench for irq_sequencer with memory model and transaction-level reference
module tb_irq_sequencer;
  import irq_sequencer_pkg::*;

  localparam int GIE = 3;

  logic        CLK = 1'b0;
  logic        RESET, REQ, INSTR_DONE, RETI_EXEC, MEM_READY;
  logic [15:0] ADDRInt, PC_IN, SR_IN, SP_IN, MEM_RDATA;
  logic [15:0] MEM_ADDR, MEM_WDATA, PC_OUT, SR_OUT, SP_OUT;
  logic        MEM_RE, MEM_WE, PC_LOAD, SR_LOAD, SP_LOAD, STALL, RTI, ISR_ACT, ERR;

  always #5 CLK = ~CLK;

  irq_sequencer #(.GIE_BIT(GIE), .MEM_TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .ADDRInt(ADDRInt), .INSTR_DONE(INSTR_DONE),
    .RETI_EXEC(RETI_EXEC), .PC_IN(PC_IN), .SR_IN(SR_IN), .SP_IN(SP_IN),
    .MEM_RDATA(MEM_RDATA), .MEM_READY(MEM_READY), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .PC_OUT(PC_OUT), .SR_OUT(SR_OUT), .SP_OUT(SP_OUT),
    .PC_LOAD(PC_LOAD), .SR_LOAD(SR_LOAD), .SP_LOAD(SP_LOAD), .STALL(STALL), .RTI(RTI),
    .ISR_ACT(ISR_ACT), .ERR(ERR)
  );

  typedef struct { logic [15:0] a; logic [15:0] d; } xact_t;
  typedef struct { logic [15:0] sp, pc, sr, vec, vdata, w0a, w1a, pco, sro, spo; } vec_t;
  typedef struct { logic [15:0] w0a, w1a, pco, sro, spo; } ent_exp_t;

  int          n_checks = 0, n_errors = 0, cyc = 0;
  int          rmode = 0;
  logic [15:0] hold_addr = '0;
  logic [15:0] mem [0:65535];
  xact_t       wq[$], rq[$];
  int          n_load = 0, n_rti = 0, n_err = 0, n_stall = 0;
  int          load_cyc = 0, rti_cyc = 0, err_cyc = 0;
  logic [15:0] ld_pc, ld_sr, ld_sp;
  logic        ld_all;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected entry behaviour from the stacking rules, including a push landing on the vector slot.
  function automatic ent_exp_t model_entry(input logic [15:0] sp, pc, sr, vec);
    ent_exp_t e;
    e.w0a = sp - 16'd2;
    e.w1a = sp - 16'd4;
    e.spo = e.w1a;
    e.sro = sr & ~(16'd1 << GIE);
    if (vec == e.w1a)      e.pco = sr;
    else if (vec == e.w0a) e.pco = pc;
    else                   e.pco = mem[vec];
    return e;
  endfunction

  task automatic tick();
    xact_t x;
    @(negedge CLK);
    cyc++;
    check("re_we_exclusive", {31'b0, MEM_RE & MEM_WE}, 32'd0);
    if (!STALL) check("mem_idle_when_not_stalled", {31'b0, MEM_RE | MEM_WE}, 32'd0);
    case (rmode)
      0:       MEM_READY = 1'b1;
      1:       MEM_READY = ($urandom_range(0, 2) != 0);
      default: MEM_READY = (MEM_ADDR != hold_addr);
    endcase
    MEM_RDATA = MEM_RE ? mem[MEM_ADDR] : 16'($urandom);
    if (MEM_WE && MEM_READY) begin
      mem[MEM_ADDR] = MEM_WDATA;
      x.a = MEM_ADDR; x.d = MEM_WDATA; wq.push_back(x);
    end
    if (MEM_RE && MEM_READY) begin
      x.a = MEM_ADDR; x.d = MEM_RDATA; rq.push_back(x);
    end
    if (PC_LOAD | SR_LOAD | SP_LOAD) begin
      n_load++; load_cyc = cyc;
      ld_pc = PC_OUT; ld_sr = SR_OUT; ld_sp = SP_OUT;
      ld_all = PC_LOAD & SR_LOAD & SP_LOAD;
    end
    if (RTI) begin n_rti++; rti_cyc = cyc; end
    if (ERR) begin n_err++; err_cyc = cyc; end
    if (STALL) n_stall++;
  endtask

  task automatic do_reset();
    RESET = 1'b1; tick(); RESET = 1'b0; tick();
    wq.delete(); rq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_wdata"}, {MEM_ADDR, MEM_WDATA}, 32'd0);
    check({tag, "_pc_sr"}, {PC_OUT, SR_OUT}, 32'd0);
    check({tag, "_sp_ctl"}, {SP_OUT, 7'd0, MEM_RE, MEM_WE, PC_LOAD, SR_LOAD, SP_LOAD,
                             STALL, RTI, ISR_ACT, ERR}, 32'd0);
  endtask

  task automatic entry_and_check(input logic [15:0] sp, pc, sr, vec, w0a, w1a, pco, sro, spo,
                                 input bit lat, output bit ok);
    int t0;
    wq.delete(); rq.delete(); n_load = 0;
    SP_IN = sp; PC_IN = pc; SR_IN = sr; ADDRInt = vec; REQ = 1'b1; INSTR_DONE = 1'b1;
    t0 = cyc;
    tick();
    REQ = 1'b0; INSTR_DONE = 1'b0;
    PC_IN = 16'($urandom); SP_IN = 16'($urandom); SR_IN = 16'($urandom); ADDRInt = 16'($urandom);
    for (int i = 0; i < 300 && n_load == 0; i++) tick();
    ok = (n_load != 0);
    check("entry_load_seen", n_load, 1);
    if (!ok) begin do_reset(); return; end
    if (lat) check("trigger_to_pc_load", load_cyc - t0, 4);
    check("entry_all_strobes", {31'b0, ld_all}, 32'd1);
    check("entry_pc_out", ld_pc, pco);
    check("entry_sr_out", ld_sr, sro);
    check("entry_sp_out", ld_sp, spo);
    check("entry_write_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("push_pc", {wq[0].a, wq[0].d}, {w0a, pc});
      check("push_sr", {wq[1].a, wq[1].d}, {w1a, sr});
    end
    check("entry_read_count", rq.size(), 1);
    if (rq.size() == 1) check("vector_fetch_addr", rq[0].a, vec);
    tick();
    check("isr_act_in_isr", {31'b0, ISR_ACT}, 32'd1);
    check("stall_low_in_isr", {31'b0, STALL}, 32'd0);
  endtask

  task automatic exit_and_check(input logic [15:0] sp_isr, exp_pc, exp_sr, exp_sp, input bit lat);
    int t0;
    wq.delete(); rq.delete(); n_load = 0; n_rti = 0;
    RETI_EXEC = 1'b1; SP_IN = sp_isr;
    t0 = cyc;
    tick();
    RETI_EXEC = 1'b0; SP_IN = 16'($urandom);
    for (int i = 0; i < 300 && n_rti == 0; i++) tick();
    check("exit_rti_seen", n_rti, 1);
    if (n_rti == 0) begin do_reset(); return; end
    if (lat) check("reti_to_rti", rti_cyc - t0, 3);
    check("exit_load_with_rti", load_cyc, rti_cyc);
    check("exit_all_strobes", {31'b0, ld_all}, 32'd1);
    check("exit_pc_out", ld_pc, exp_pc);
    check("exit_sr_out", ld_sr, exp_sr);
    check("exit_sp_out", ld_sp, exp_sp);
    check("exit_read_count", rq.size(), 2);
    if (rq.size() == 2) begin
      check("pop_sr_addr", rq[0].a, sp_isr);
      check("pop_pc_addr", rq[1].a, 16'(sp_isr + 16'd2));
    end
    check("exit_write_count", wq.size(), 0);
    tick(); tick();
    check("rti_single_pulse", n_rti, 1);
    check("idle_after_exit", {30'b0, STALL, ISR_ACT}, 32'd0);
  endtask

  vec_t tbl[4];

  initial begin
    bit ok;
    RESET = 1'b1; REQ = 0; INSTR_DONE = 0; RETI_EXEC = 0; MEM_READY = 1'b1;
    ADDRInt = '0; PC_IN = '0; SR_IN = '0; SP_IN = '0; MEM_RDATA = '0;
    tbl[0] = '{16'h0400, 16'h1234, 16'h0008, VEC_SLOT_3, 16'hC000, 16'h03FE, 16'h03FC, 16'hC000, 16'h0000, 16'h03FC};
    tbl[1] = '{16'h0002, 16'hABCD, 16'h000F, VEC_SLOT_0, 16'h8000, 16'h0000, 16'hFFFE, 16'h8000, 16'h0007, 16'hFFFE};
    tbl[2] = '{16'h0000, 16'h5555, 16'hFFFF, VEC_SLOT_2, 16'h1111, 16'hFFFE, 16'hFFFC, 16'h1111, 16'hFFF7, 16'hFFFC};
    tbl[3] = '{16'hFFFE, 16'h0F0F, 16'h0108, VEC_SLOT_1, 16'h2468, 16'hFFFC, 16'hFFFA, 16'h2468, 16'h0100, 16'hFFFA};

    @(posedge CLK); @(posedge CLK);
    tick();
    check_all_zero("reset_state");
    RESET = 1'b0;
    tick();

    rmode = 0;
    for (int i = 0; i < 4; i++) begin
      mem[tbl[i].vec] = tbl[i].vdata;
      entry_and_check(tbl[i].sp, tbl[i].pc, tbl[i].sr, tbl[i].vec, tbl[i].w0a, tbl[i].w1a,
                      tbl[i].pco, tbl[i].sro, tbl[i].spo, 1'b1, ok);
      if (ok) exit_and_check(tbl[i].spo, tbl[i].pc, tbl[i].sr, tbl[i].sp, 1'b1);
    end

    // GIE clear, missing instruction boundary, and RETI while idle
    wq.delete(); rq.delete(); n_stall = 0; n_load = 0; n_rti = 0;
    REQ = 1'b1; SR_IN = 16'h0000; INSTR_DONE = 1'b1; ADDRInt = VEC_SLOT_3;
    repeat (6) tick();
    check("gie_clear_no_stall", n_stall, 0);
    check("gie_clear_no_writes", wq.size(), 0);
    SR_IN = 16'h0008; INSTR_DONE = 1'b0;
    repeat (4) tick();
    check("no_boundary_no_stall", n_stall, 0);
    REQ = 1'b0; RETI_EXEC = 1'b1;
    tick();
    RETI_EXEC = 1'b0;
    repeat (4) tick();
    check("reti_in_idle_no_rti", n_rti, 0);
    check("reti_in_idle_no_reads", rq.size(), 0);
    check("reti_in_idle_no_load", n_load, 0);

    // REQ ignored in ISR, RETI wins over REQ, request during EXIT waits for INSTR_DONE
    mem[VEC_SLOT_1] = 16'h4000;
    entry_and_check(16'h0800, 16'h0100, 16'h0008, VEC_SLOT_1, 16'h07FE, 16'h07FC,
                    16'h4000, 16'h0000, 16'h07FC, 1'b1, ok);
    if (ok) begin
      wq.delete(); rq.delete(); n_stall = 0;
      REQ = 1'b1; SR_IN = 16'h0008; INSTR_DONE = 1'b1; ADDRInt = VEC_SLOT_0;
      repeat (5) tick();
      check("req_in_isr_no_stall", n_stall, 0);
      check("req_in_isr_no_mem", wq.size() + rq.size(), 0);
      check("req_in_isr_still_isr", {31'b0, ISR_ACT}, 32'd1);
      INSTR_DONE = 1'b0;
      exit_and_check(16'h07FC, 16'h0100, 16'h0008, 16'h0800, 1'b1);
      wq.delete(); n_stall = 0;
      repeat (4) tick();
      check("exit_req_waits_no_stall", n_stall, 0);
      check("exit_req_waits_no_writes", wq.size(), 0);
      mem[VEC_SLOT_0] = 16'h5A5A;
      entry_and_check(16'h0600, 16'h0222, 16'h0008, VEC_SLOT_0, 16'h05FE, 16'h05FC,
                      16'h5A5A, 16'h0000, 16'h05FC, 1'b1, ok);
      if (ok) exit_and_check(16'h05FC, 16'h0222, 16'h0008, 16'h0600, 1'b1);
    end

    // Reset while PUSH_SR is waiting on memory
    rmode = 3; hold_addr = 16'h03FC;
    SP_IN = 16'h0400; PC_IN = 16'h1234; SR_IN = 16'h0008; ADDRInt = VEC_SLOT_3;
    REQ = 1'b1; INSTR_DONE = 1'b1;
    tick();
    REQ = 1'b0; INSTR_DONE = 1'b0;
    repeat (4) tick();
    check("stuck_push_sr", {MEM_ADDR, 15'd0, MEM_WE}, {16'h03FC, 16'h0001});
    RESET = 1'b1;
    tick();
    check_all_zero("reset_mid_push");
    RESET = 1'b0; n_load = 0;
    tick();
    check_all_zero("after_reset_release");
    rmode = 0;

`ifdef MEM_TIMEOUT_EN
    begin
      int f0;
      f0 = -1;
      rmode = 3; hold_addr = VEC_SLOT_1; n_err = 0; n_load = 0;
      SP_IN = 16'h0200; PC_IN = 16'h0777; SR_IN = 16'h0008; ADDRInt = VEC_SLOT_1;
      REQ = 1'b1; INSTR_DONE = 1'b1;
      tick();
      REQ = 1'b0; INSTR_DONE = 1'b0;
      for (int i = 0; i < 20 && f0 < 0; i++) begin
        tick();
        if (MEM_RE) f0 = cyc;
      end
      for (int i = 0; i < 40 && n_err == 0; i++) tick();
      check("timeout_err_seen", n_err, 1);
      check("timeout_err_latency", err_cyc - f0, 16);
      check("timeout_stall_dropped", {31'b0, STALL}, 32'd0);
      tick();
      check("timeout_err_one_pulse", n_err, 1);
      check("timeout_no_load", n_load, 0);
      rmode = 0;
    end
`endif

    // Randomized entries/exits against the transaction-level model
    for (int it = 0; it < 30; it++) begin
      logic [15:0] sp, pc, sr, vec;
      ent_exp_t    e;
      rmode = $urandom_range(0, 1);
      sp = 16'($urandom) & 16'hFFFE;
      pc = 16'($urandom);
      sr = 16'($urandom);
      sr[GIE] = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       vec = VEC_SLOT_0;
        1:       vec = VEC_SLOT_1;
        2:       vec = VEC_SLOT_2;
        default: vec = VEC_SLOT_3;
      endcase
      mem[vec] = 16'($urandom);
      if (!sr[GIE]) begin
        n_stall = 0; wq.delete();
        REQ = 1'b1; INSTR_DONE = 1'b1; SR_IN = sr;
        repeat (3) tick();
        REQ = 1'b0; INSTR_DONE = 1'b0;
        check("rand_gie_clear_no_stall", n_stall, 0);
        check("rand_gie_clear_no_writes", wq.size(), 0);
      end else begin
        e = model_entry(sp, pc, sr, vec);
        entry_and_check(sp, pc, sr, vec, e.w0a, e.w1a, e.pco, e.sro, e.spo, rmode == 0, ok);
        if (ok) begin
          repeat ($urandom_range(0, 5)) tick();
          exit_and_check(e.spo, pc, sr, sp, rmode == 0);
        end
      end
    end

`ifndef MEM_TIMEOUT_EN
    check("err_tied_low", n_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL have parameter GIE_BIT, default 3: bit position of the global interrupt enable in the status word.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: maximum wait cycles per memory access (used only under REQ-032).
REQ-003 SHALL have ports, clock and reset first:
 CLK  in  1  single clock, all logic on rising edge
 RESET  in  1  synchronous, active-high reset
 REQ  in  1  pending interrupt from the interrupt controller
 ADDRInt  in  16  vector address from the interrupt controller
 INSTR_DONE  in  1  instruction-boundary pulse from the core
 RETI_EXEC  in  1  one-cycle pulse, RETI decoded by the core
 PC_IN, SR_IN, SP_IN  in  16 each  current core registers
 MEM_RDATA  in  16  read data;  MEM_READY  in  1  access complete
 MEM_ADDR  out  16;  MEM_WDATA  out  16;  MEM_RE, MEM_WE  out  1
 PC_OUT, SR_OUT, SP_OUT  out  16 each;  PC_LOAD, SR_LOAD, SP_LOAD  out  1  one-cycle register-load strobes
 STALL  out  1  freezes the core fetch/execute
 RTI  out  1  one-cycle pulse that clears the interrupt controller
 ISR_ACT  out  1  high while an interrupt handler is running
 ERR  out  1  one-cycle pulse on aborted sequence (REQ-032 only)
REQ-004 SHALL use one clock (CLK); RESET SHALL be synchronous and active-high.

Function
REQ-010 SHALL implement states IDLE, PUSH_PC, PUSH_SR, FETCH_VEC, ENTER, ISR, POP_SR, POP_PC, EXIT.
REQ-011 IDLE -> PUSH_PC when REQ & SR_IN[GIE_BIT] & INSTR_DONE in the same cycle; SHALL latch ADDRInt, PC_IN, SR_IN, SP_IN that cycle.
REQ-012 STALL SHALL be 1 in every state except IDLE and ISR.
REQ-013 PUSH_PC: MEM_WE=1, MEM_ADDR=SP-2, MEM_WDATA=saved PC; held until MEM_READY, then PUSH_SR.
REQ-014 PUSH_SR: MEM_WE=1, MEM_ADDR=SP-4, MEM_WDATA=saved SR; on MEM_READY -> FETCH_VEC.
REQ-015 FETCH_VEC: MEM_RE=1, MEM_ADDR=latched vector; on MEM_READY capture MEM_RDATA -> ENTER.
REQ-016 ENTER (1 cycle): PC_OUT=fetched vector, SR_OUT=saved SR with GIE_BIT cleared, SP_OUT=SP-4, all three LOAD strobes high; -> ISR.
REQ-017 ISR: ISR_ACT=1; REQ ignored; RETI_EXEC -> POP_SR, latching SP_IN.
REQ-018 POP_SR: MEM_RE=1, MEM_ADDR=SP; capture on MEM_READY -> POP_PC.
REQ-019 POP_PC: MEM_RE=1, MEM_ADDR=SP+2; capture on MEM_READY -> EXIT.
REQ-020 EXIT (1 cycle): SR_OUT/PC_OUT=popped values, SP_OUT=SP+4, all LOAD strobes high, RTI=1; -> IDLE.
REQ-021 Stack arithmetic SHALL be 16-bit modulo (0x0002-4 = 0xFFFE).
REQ-022 RETI_EXEC outside ISR SHALL be ignored; RETI_EXEC and REQ together in ISR: RETI wins.
REQ-023 MEM_RE and MEM_WE SHALL never be high together; both low outside memory states.
REQ-024 Latency with MEM_READY tied high: trigger to PC_LOAD = 4 cycles; RETI_EXEC to RTI = 3 cycles.
REQ-025 A request arriving during EXIT SHALL be accepted no earlier than the next INSTR_DONE in IDLE.

Reset
REQ-030 RESET SHALL force IDLE, abandon any memory access, and drive every output to 0 the following cycle.

Configuration
REQ-032 With MEM_TIMEOUT_EN defined: a memory state waiting MEM_TIMEOUT cycles without MEM_READY SHALL pulse ERR, drop STALL, return to IDLE with no LOAD strobes; without it, waits are unbounded and ERR is tied 0.

Structure
REQ-040 Shared package SHALL hold the state enum, vector-table constants (FFF0/FFF2/FFFA/FFFC) and stack-step constant 2.
REQ-041 Timeout counter SHALL be sub-module irq_mem_timer; remainder flat.

Verification
REQ-050 SP=0x0400, PC=0x1234, SR=0x0008, REQ with ADDRInt=0xFFFC (mem[FFFC]=0xC000) -> writes 0x1234@0x03FE, 0x0008@0x03FC; PC_OUT=0xC000, SR_OUT=0x0000, SP_OUT=0x03FC.
REQ-051 RETI_EXEC in ISR, SP=0x03FC -> reads 0x03FC, 0x03FE; PC_OUT=0x1234, SR_OUT=0x0008, SP_OUT=0x0400, RTI one cycle.
REQ-052 REQ=1 with SR_IN=0x0000 -> stays IDLE, STALL=0; RETI_EXEC in IDLE -> no RTI.
REQ-053 SP=0x0002 entry -> writes at 0x0000 and 0xFFFE, SP_OUT=0xFFFE.
REQ-054 RESET asserted during PUSH_SR with MEM_READY=0 -> next cycle IDLE, all outputs 0.
REQ-055 MEM_TIMEOUT_EN, MEM_READY held 0 in FETCH_VEC -> ERR after 16 cycles, IDLE, no PC_LOAD.
